// File: rtl/ring_cpu_pkg.sv
// ring_cpu_pkg -- shared definitions for the ring_cpu_core pipeline.
//
// Contents: opcode and ALU function codes, the ID->EX and EX->WB stage
// records, the NOP constants, and the ALU / address-decode helpers.
//
// Bit numbering: the architecture numbers bits MSB-first (bit 0 = MSB).
// Vectors here are declared [W-1:0], so architectural bit i of a W-bit
// field is vector bit W-1-i. For example, opcode [0:5] is instr[31:26],
// imm16 [16:31] is instr[15:0], and the shift amount rB[58:63] is rb[5:0].
package ring_cpu_pkg;

  localparam int XLEN = 64;

  localparam logic [5:0] OP_NOP  = 6'b000000;
  localparam logic [5:0] OP_ALU  = 6'b101010;
  localparam logic [5:0] OP_LD   = 6'b100000;
  localparam logic [5:0] OP_SD   = 6'b100001;
  localparam logic [5:0] OP_BEZ  = 6'b100010;
  localparam logic [5:0] OP_BNEZ = 6'b100011;

  localparam logic [5:0] FN_ADD = 6'd1;
  localparam logic [5:0] FN_SUB = 6'd2;
  localparam logic [5:0] FN_AND = 6'd3;
  localparam logic [5:0] FN_OR  = 6'd4;
  localparam logic [5:0] FN_XOR = 6'd5;
  localparam logic [5:0] FN_NOT = 6'd6;
  localparam logic [5:0] FN_MOV = 6'd7;
  localparam logic [5:0] FN_SLL = 6'd8;
  localparam logic [5:0] FN_SRL = 6'd9;
  localparam logic [5:0] FN_SRA = 6'd10;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0000;

  // Instruction as it sits in EX. op_b carries rB for ALU ops and the rD
  // value (store data) for SD.
  typedef struct packed {
    logic            valid;
    logic [5:0]      opcode;
    logic [5:0]      func;
    logic [4:0]      rd;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [15:0]     imm16;
    logic            wr;
  } ex_stage_t;

  // Instruction as it sits in WB. Load data is not stored here: it arrives
  // on the memory/NIC read bus during WB.
  typedef struct packed {
    logic            wr;
    logic            load;
    logic            nic;
    logic [4:0]      rd;
    logic [XLEN-1:0] result;
  } wb_stage_t;

  localparam ex_stage_t EX_NOP = '0;
  localparam wb_stage_t WB_NOP = '0;

  function automatic logic alu_func_known(input logic [5:0] f);
    return (f >= FN_ADD) && (f <= FN_SRA);
  endfunction

  // The top two imm16 bits set select the NIC window.
  function automatic logic nic_select(input logic [15:0] imm);
    return imm[15:14] == 2'b11;
  endfunction

  function automatic logic [XLEN-1:0] alu_exec(input logic [5:0] f,
                                               input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
    logic [5:0] sh;
    sh = b[5:0];
    case (f)
      FN_ADD:  return a + b;
      FN_SUB:  return a - b;
      FN_AND:  return a & b;
      FN_OR:   return a | b;
      FN_XOR:  return a ^ b;
      FN_NOT:  return ~a;
      FN_MOV:  return a;
      FN_SLL:  return a << sh;
      FN_SRL:  return a >> sh;
      FN_SRA:  return $signed(a) >>> sh;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/ring_cpu_regfile.sv
// ring_cpu_regfile -- 32 x 64-bit register file, three read ports, one write.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   ra/rb/rd_addr, _data  combinational read ports used by ID
//   wr_en, wr_addr, wr_data  write port driven by WB
//
// R0 always reads zero and ignores writes. A write in the current cycle is
// bypassed to the read ports (write-through), so WB results never stall ID.
module ring_cpu_regfile
  import ring_cpu_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      ra_addr,
  input  logic [4:0]      rb_addr,
  input  logic [4:0]      rd_addr,
  output logic [XLEN-1:0] ra_data,
  output logic [XLEN-1:0] rb_data,
  output logic [XLEN-1:0] rd_data,
  input  logic            wr_en,
  input  logic [4:0]      wr_addr,
  input  logic [XLEN-1:0] wr_data
);

  logic [XLEN-1:0] regFile [0:31];

  function automatic logic [XLEN-1:0] read_port(input logic [4:0]      a,
                                                input logic [XLEN-1:0] stored,
                                                input logic            we,
                                                input logic [4:0]      wa,
                                                input logic [XLEN-1:0] wd);
    if (a == 5'd0)          return '0;
    else if (we && wa == a) return wd;
    else                    return stored;
  endfunction

  assign ra_data = read_port(ra_addr, regFile[ra_addr], wr_en, wr_addr, wr_data);
  assign rb_data = read_port(rb_addr, regFile[rb_addr], wr_en, wr_addr, wr_data);
  assign rd_data = read_port(rd_addr, regFile[rd_addr], wr_en, wr_addr, wr_data);

  // NOTE: this array is reset on purpose -- software relies on every
  // register reading zero after reset, so it is built from resettable flops
  // rather than a RAM macro.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regFile[i] <= '0;
    end else if (wr_en && wr_addr != 5'd0) begin
      regFile[wr_addr] <= wr_data;
    end
  end

endmodule

// File: rtl/ring_cpu_core.sv
// ring_cpu_core -- 64-bit 4-stage (IF, ID, EX, WB) in-order core for a
// ring-NoC node.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   instrIn / instrAddr        combinational instruction memory (byte PC)
//   dmemAddr/En/WrEn/DataOut   synchronous data memory request, driven in EX
//   dmemDataIn                 data memory read data, one cycle after request
//   nicAddr/En/WrEn/DataOut    NIC register window request, driven in EX
//   nicDataIn                  NIC read data, one cycle after request
//
// Build option: define CPU_FWD_EN to forward ALU results from EX to ID.
// Loads in EX still cost one stall cycle.
//
// Branches resolve in ID; a taken branch squashes the one instruction
// fetched behind it. Register hazards against the EX stage stall IF/ID for
// one cycle and inject a bubble; WB hazards are covered by write-through.
module ring_cpu_core
  import ring_cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          DATA_W   = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       instrIn,
  output logic [31:0]       instrAddr,
  input  logic [DATA_W-1:0] dmemDataIn,
  output logic [31:0]       dmemAddr,
  output logic              dmemEn,
  output logic              dmemWrEn,
  output logic [DATA_W-1:0] dmemDataOut,
  input  logic [DATA_W-1:0] nicDataIn,
  output logic [1:0]        nicAddr,
  output logic              nicEn,
  output logic              nicWrEn,
  output logic [DATA_W-1:0] nicDataOut
);

  logic [31:0]     pc, if_id;
  ex_stage_t       ex_q, id_rec;
  wb_stage_t       wb_q, wb_next;
  logic [XLEN-1:0] ra_data, rb_data, rd_data, ra_op, rb_op, rd_op;
  logic [XLEN-1:0] ex_result, wb_data;
  logic            dep, stall, taken;

  // ---------------- ID: decode, operands, hazards, branches ----------------
  logic [5:0]  id_op, id_func;
  logic [4:0]  id_rd, id_ra, id_rb;
  logic [15:0] id_imm;
  logic        is_alu, is_ld, is_sd, is_bez, is_bnez;

  assign id_op   = if_id[31:26];
  assign id_rd   = if_id[25:21];
  assign id_ra   = if_id[20:16];
  assign id_rb   = if_id[15:11];
  assign id_imm  = if_id[15:0];
  assign id_func = if_id[5:0];

  assign is_alu  = id_op == OP_ALU;
  assign is_ld   = id_op == OP_LD;
  assign is_sd   = id_op == OP_SD;
  assign is_bez  = id_op == OP_BEZ;
  assign is_bnez = id_op == OP_BNEZ;

  ring_cpu_regfile regFile (
    .clk     (clk),
    .reset   (reset),
    .ra_addr (id_ra),
    .rb_addr (id_rb),
    .rd_addr (id_rd),
    .ra_data (ra_data),
    .rb_data (rb_data),
    .rd_data (rd_data),
    .wr_en   (wb_q.wr),
    .wr_addr (wb_q.rd),
    .wr_data (wb_data)
  );

  // ex_q.wr is never set for R0, so R0 never creates a dependence.
  assign dep = ex_q.wr &&
               ((is_alu && (ex_q.rd == id_ra || ex_q.rd == id_rb)) ||
                ((is_sd || is_bez || is_bnez) && ex_q.rd == id_rd));

`ifdef CPU_FWD_EN
  logic ex_fwd;
  assign ex_fwd = ex_q.wr && ex_q.opcode == OP_ALU;
  assign ra_op  = (ex_fwd && ex_q.rd == id_ra) ? ex_result : ra_data;
  assign rb_op  = (ex_fwd && ex_q.rd == id_rb) ? ex_result : rb_data;
  assign rd_op  = (ex_fwd && ex_q.rd == id_rd) ? ex_result : rd_data;
  // Load data does not exist until WB, so a load in EX still stalls.
  assign stall  = dep && ex_q.opcode == OP_LD;
`else
  assign ra_op  = ra_data;
  assign rb_op  = rb_data;
  assign rd_op  = rd_data;
  assign stall  = dep;
`endif

  assign taken = !stall && ((is_bez  && rd_op == '0) ||
                            (is_bnez && rd_op != '0));

  // NOTE: every field gets a value from the default before any condition,
  // so no path leaves id_rec unassigned and no latch is inferred.
  always_comb begin
    id_rec        = EX_NOP;
    id_rec.valid  = is_alu || is_ld || is_sd || is_bez || is_bnez;
    id_rec.opcode = id_op;
    id_rec.func   = id_func;
    id_rec.rd     = id_rd;
    id_rec.imm16  = id_imm;
    id_rec.op_a   = ra_op;
    id_rec.op_b   = is_alu ? rb_op : rd_op;
    id_rec.wr     = (id_rd != 5'd0) &&
                    ((is_alu && alu_func_known(id_func)) || is_ld);
  end

  // ---------------- EX: ALU and memory/NIC request ----------------
  logic ex_mem, ex_st, ex_nic;

  assign ex_result = alu_exec(ex_q.func, ex_q.op_a, ex_q.op_b);
  assign ex_mem    = ex_q.valid && (ex_q.opcode == OP_LD || ex_q.opcode == OP_SD);
  assign ex_st     = ex_q.valid && ex_q.opcode == OP_SD;
  assign ex_nic    = nic_select(ex_q.imm16);

  assign dmemEn      = ex_mem && !ex_nic;
  assign dmemWrEn    = ex_st  && !ex_nic;
  assign dmemAddr    = dmemEn   ? {16'h0, ex_q.imm16} : '0;
  assign dmemDataOut = dmemWrEn ? ex_q.op_b : '0;
  assign nicEn       = ex_mem && ex_nic;
  assign nicWrEn     = ex_st  && ex_nic;
  assign nicAddr     = nicEn   ? ex_q.imm16[1:0] : '0;
  assign nicDataOut  = nicWrEn ? ex_q.op_b : '0;

  always_comb begin
    wb_next        = WB_NOP;
    wb_next.wr     = ex_q.wr;
    wb_next.load   = ex_q.opcode == OP_LD;
    wb_next.nic    = ex_nic;
    wb_next.rd     = ex_q.rd;
    wb_next.result = ex_result;
  end

  // ---------------- WB ----------------
  assign wb_data = !wb_q.load ? wb_q.result :
                   (wb_q.nic ? nicDataIn : dmemDataIn);

  // ---------------- Pipeline registers ----------------
  assign instrAddr = pc;

  // NOTE: state registers use non-blocking assignments so every stage
  // samples the values its neighbours held before this edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc    <= RESET_PC;
      if_id <= INSTR_NOP;
      ex_q  <= EX_NOP;
      wb_q  <= WB_NOP;
    end else begin
      wb_q <= wb_next;
      if (stall) begin
        ex_q <= EX_NOP;
      end else begin
        ex_q <= id_rec;
        if (taken) begin
          pc    <= {16'h0, id_imm};
          if_id <= INSTR_NOP;
        end else begin
          pc    <= pc + 32'd4;
          if_id <= instrIn;
        end
      end
    end
  end

endmodule

// File: tb/tb_ring_cpu_core.sv
// tb_ring_cpu_core -- self-checking bench for ring_cpu_core.
// Table-driven ALU vectors, directed multi-cycle sequences (store pulse,
// branch squash, hazard stall, NIC window, reset during a store) and random
// programs compared against an instruction-level interpreter.
module tb_ring_cpu_core;

  localparam logic [5:0] T_ALU = 6'b101010, T_LD = 6'b100000, T_SD = 6'b100001;
  localparam logic [5:0] T_BEZ = 6'b100010, T_BNEZ = 6'b100011;
  localparam logic [31:0] NOP1 = 32'h0400_0000;   // unknown opcode, runs as NOP

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instrIn, instrAddr, dmemAddr;
  logic [63:0] dmemDataIn = '0, nicDataIn = '0, dmemDataOut, nicDataOut;
  logic        dmemEn, dmemWrEn, nicEn, nicWrEn;
  logic [1:0]  nicAddr;

  logic [31:0] imem [0:255];
  logic [63:0] dmem [0:255];
  logic [63:0] nic  [0:3];
  logic [63:0] m_reg [0:31];
  logic [63:0] m_mem [0:255];
  logic [63:0] m_nic [0:3];

  int checks = 0;
  int failures = 0;

  ring_cpu_core dut (
    .clk(clk), .reset(reset), .instrIn(instrIn), .instrAddr(instrAddr),
    .dmemDataIn(dmemDataIn), .dmemAddr(dmemAddr), .dmemEn(dmemEn),
    .dmemWrEn(dmemWrEn), .dmemDataOut(dmemDataOut), .nicDataIn(nicDataIn),
    .nicAddr(nicAddr), .nicEn(nicEn), .nicWrEn(nicWrEn), .nicDataOut(nicDataOut)
  );

  always #5 clk = ~clk;

  assign instrIn = imem[instrAddr[9:2]];

  always @(posedge clk) begin
    if (dmemEn) begin
      if (dmemWrEn) dmem[dmemAddr[7:0]] <= dmemDataOut;
      else          dmemDataIn <= dmem[dmemAddr[7:0]];
    end
    if (nicEn) begin
      if (nicWrEn) nic[nicAddr] <= nicDataOut;
      else         nicDataIn <= nic[nicAddr];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] i_alu(input logic [4:0] rd, input logic [4:0] ra,
                                        input logic [4:0] rb, input logic [5:0] fn);
    return {T_ALU, rd, ra, rb, 5'b0, fn};
  endfunction

  function automatic logic [31:0] i_mem(input logic [5:0] op, input logic [4:0] rd,
                                        input logic [15:0] imm);
    return {op, rd, 5'b0, imm};
  endfunction

  task automatic clear_all();
    for (int i = 0; i < 256; i++) begin imem[i] = '0; dmem[i] = '0; end
    for (int i = 0; i < 4; i++) nic[i] = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Instruction-level interpreter: one instruction at a time, no pipeline.
  task automatic model_run();
    logic [31:0] pc, w;
    logic [63:0] a, b, d, r;
    logic [15:0] imm;
    logic        ok;
    for (int i = 0; i < 32; i++) m_reg[i] = '0;
    for (int i = 0; i < 256; i++) m_mem[i] = dmem[i];
    for (int i = 0; i < 4; i++) m_nic[i] = nic[i];
    pc = 32'h0;
    for (int s = 0; s < 512; s++) begin
      w = imem[pc[9:2]];
      if (w == 32'h0) break;
      imm = w[15:0];
      a = m_reg[w[20:16]];
      b = m_reg[w[15:11]];
      d = m_reg[w[25:21]];
      pc = pc + 4;
      case (w[31:26])
        T_ALU: begin
          ok = 1'b1;
          r = '0;
          case (w[5:0])
            6'd1:  r = a + b;
            6'd2:  r = a - b;
            6'd3:  r = a & b;
            6'd4:  r = a | b;
            6'd5:  r = a ^ b;
            6'd6:  r = ~a;
            6'd7:  r = a;
            6'd8:  r = a << b[5:0];
            6'd9:  r = a >> b[5:0];
            6'd10: r = $signed(a) >>> b[5:0];
            default: ok = 1'b0;
          endcase
          if (ok && w[25:21] != 5'd0) m_reg[w[25:21]] = r;
        end
        T_LD: begin
          r = (imm[15:14] == 2'b11) ? m_nic[imm[1:0]] : m_mem[imm[7:0]];
          if (w[25:21] != 5'd0) m_reg[w[25:21]] = r;
        end
        T_SD: begin
          if (imm[15:14] == 2'b11) m_nic[imm[1:0]] = d;
          else                     m_mem[imm[7:0]] = d;
        end
        T_BEZ:  if (d == 64'd0) pc = {16'h0, imm};
        T_BNEZ: if (d != 64'd0) pc = {16'h0, imm};
        default: ;
      endcase
    end
  endtask

  typedef struct {
    logic [5:0]  fn;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
  } alu_vec_t;

  alu_vec_t vecs [13];

  initial begin
    int cnt, wr_cnt, dm_cnt;
    logic [63:0] cap_addr, cap_data;
    logic found;

    vecs[0]  = '{6'd1,  64'd5, 64'd3, 64'd8};
    vecs[1]  = '{6'd2,  64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE};
    vecs[2]  = '{6'd3,  64'hF0F0, 64'hFF00, 64'hF000};
    vecs[3]  = '{6'd4,  64'hF0F0, 64'h0F0F, 64'hFFFF};
    vecs[4]  = '{6'd5,  64'hFFFF, 64'h0F0F, 64'hF0F0};
    vecs[5]  = '{6'd6,  64'd0, 64'd9, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[6]  = '{6'd7,  64'h1234, 64'd7, 64'h1234};
    vecs[7]  = '{6'd8,  64'd1, 64'd63, 64'h8000_0000_0000_0000};
    vecs[8]  = '{6'd9,  64'h8000_0000_0000_0000, 64'd4, 64'h0800_0000_0000_0000};
    vecs[9]  = '{6'd10, 64'h8000_0000_0000_0000, 64'd4, 64'hF800_0000_0000_0000};
    vecs[10] = '{6'd8,  64'd1, 64'h42, 64'd4};
    vecs[11] = '{6'd1,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0};
    vecs[12] = '{6'h3F, 64'd5, 64'd3, 64'd0};

    // ---- reset state ----
    clear_all();
    reset = 1'b1;
    @(negedge clk);
    check("rst_pc", instrAddr, 32'h0);
    check("rst_dmemEn", dmemEn, 0);
    check("rst_dmemWrEn", dmemWrEn, 0);
    check("rst_nicEn", nicEn, 0);
    check("rst_nicWrEn", nicWrEn, 0);
    check("rst_dmemAddr", dmemAddr, 0);
    check("rst_nicAddr", nicAddr, 0);
    check("rst_r31", dut.regFile.regFile[31], 0);

    // ---- ALU vector table (loads feed the ALU directly: load-use stall) ----
    for (int v = 0; v < 13; v++) begin
      clear_all();
      dmem[0] = vecs[v].a;
      dmem[1] = vecs[v].b;
      imem[0] = i_mem(T_LD, 5'd1, 16'd0);
      imem[1] = i_mem(T_LD, 5'd2, 16'd1);
      imem[2] = i_alu(5'd3, 5'd1, 5'd2, vecs[v].fn);
      do_reset();
      repeat (15) @(negedge clk);
      check($sformatf("alu_vec%0d", v), dut.regFile.regFile[3], vecs[v].exp);
    end

    // ---- ALU chain + store pulse ----
    clear_all();
    dmem[0] = 64'd5;
    dmem[1] = 64'd3;
    imem[0] = i_mem(T_LD, 5'd1, 16'd0);
    imem[1] = i_mem(T_LD, 5'd2, 16'd1);
    imem[2] = i_alu(5'd3, 5'd1, 5'd2, 6'd1);
    imem[3] = i_alu(5'd4, 5'd1, 5'd2, 6'd2);
    imem[4] = i_alu(5'd5, 5'd1, 5'd2, 6'd8);
    imem[5] = i_mem(T_SD, 5'd3, 16'd4);
    do_reset();
    wr_cnt = 0; cap_addr = '0; cap_data = '0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (dmemEn && dmemWrEn) begin
        wr_cnt++; cap_addr = 64'(dmemAddr); cap_data = dmemDataOut;
      end
    end
    check("chain_r3", dut.regFile.regFile[3], 64'd8);
    check("chain_r4", dut.regFile.regFile[4], 64'd2);
    check("chain_r5", dut.regFile.regFile[5], 64'd40);
    check("store_pulses", 64'(wr_cnt), 64'd1);
    check("store_addr", cap_addr, 64'd4);
    check("store_data", cap_data, 64'd8);
    check("store_mem4", dmem[4], 64'd8);

    // ---- hazard: ADD R7=R1+R1 ; ADD R8=R7+R7 ----
    clear_all();
    dmem[0] = 64'd5;
    imem[0] = i_mem(T_LD, 5'd1, 16'd0);
    imem[1] = NOP1;
    imem[2] = NOP1;
    imem[3] = i_alu(5'd7, 5'd1, 5'd1, 6'd1);
    imem[4] = i_alu(5'd8, 5'd7, 5'd7, 6'd1);
    do_reset();
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (instrAddr == 32'h14) cnt++;
    end
`ifdef CPU_FWD_EN
    check("hazard_hold_cycles", 64'(cnt), 64'd1);
`else
    check("hazard_hold_cycles", 64'(cnt), 64'd2);
`endif
    check("hazard_r8", dut.regFile.regFile[8], 64'd20);

    // ---- branch: BEZ R6 -> 0x20, squash the next sequential op ----
    clear_all();
    imem[0] = i_alu(5'd6, 5'd0, 5'd0, 6'd1);
    imem[1] = NOP1;
    imem[2] = i_mem(T_BEZ, 5'd6, 16'h0020);
    imem[3] = i_alu(5'd10, 5'd0, 5'd0, 6'd6);
    imem[8] = i_alu(5'd11, 5'd0, 5'd0, 6'd6);
    do_reset();
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      if (instrAddr == 32'h8) found = 1'b1;
      else @(negedge clk);
    end
    check("br_fetch_seen", 64'(found), 64'd1);
    @(negedge clk);
    check("br_pc_plus1", instrAddr, 32'h0C);
    @(negedge clk);
    check("br_pc_target", instrAddr, 32'h20);
    repeat (10) @(negedge clk);
    check("br_squashed_r10", dut.regFile.regFile[10], 64'd0);
    check("br_target_r11", dut.regFile.regFile[11], 64'hFFFF_FFFF_FFFF_FFFF);

    // ---- NIC window ----
    clear_all();
    nic[0] = 64'd5;
    nic[3] = 64'hAA;
    imem[0] = i_mem(T_LD, 5'd1, 16'hC000);
    imem[1] = i_mem(T_SD, 5'd1, 16'hC002);
    imem[2] = i_mem(T_LD, 5'd9, 16'hC003);
    do_reset();
    wr_cnt = 0; dm_cnt = 0; cap_addr = '0; cap_data = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (dmemEn) dm_cnt++;
      if (nicEn && nicWrEn) begin
        wr_cnt++; cap_addr = 64'(nicAddr); cap_data = nicDataOut;
      end
    end
    check("nic_dmem_quiet", 64'(dm_cnt), 64'd0);
    check("nic_writes", 64'(wr_cnt), 64'd1);
    check("nic_addr", cap_addr, 64'd2);
    check("nic_data", cap_data, 64'd5);
    check("nic_reg2", nic[2], 64'd5);
    check("nic_r9", dut.regFile.regFile[9], 64'hAA);

    // ---- reset during a store's EX cycle ----
    clear_all();
    dmem[0] = 64'd5;
    dmem[1] = 64'd3;
    dmem[4] = 64'hDEAD;
    imem[0] = i_mem(T_LD, 5'd1, 16'd0);
    imem[1] = i_mem(T_LD, 5'd2, 16'd1);
    imem[2] = i_alu(5'd3, 5'd1, 5'd2, 6'd1);
    imem[3] = i_mem(T_SD, 5'd3, 16'd4);
    do_reset();
    found = 1'b0;
    for (int c = 0; c < 30 && !found; c++) begin
      @(negedge clk);
      if (dmemEn && dmemWrEn) found = 1'b1;
    end
    check("rstmid_store_seen", 64'(found), 64'd1);
    reset = 1'b1;
    #1;
    check("rstmid_dmemEn", dmemEn, 0);
    check("rstmid_dmemWrEn", dmemWrEn, 0);
    check("rstmid_nicEn", nicEn, 0);
    check("rstmid_pc", instrAddr, 32'h0);
    check("rstmid_r1", dut.regFile.regFile[1], 0);
    check("rstmid_r3", dut.regFile.regFile[3], 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rstmid_no_write", dmem[4], 64'hDEAD);

    // ---- random programs against the interpreter ----
    for (int p = 0; p < 25; p++) begin
      int n;
      logic [4:0]  rd, ra, rb;
      logic [15:0] imm;
      logic [5:0]  fn;
      clear_all();
      for (int i = 0; i < 8; i++) dmem[i] = {$urandom, $urandom};
      for (int i = 0; i < 4; i++) nic[i] = {$urandom, $urandom};
      n = 8 + $urandom_range(0, 16);
      for (int i = 0; i < n; i++) begin
        rd  = 5'($urandom_range(0, 7));
        ra  = 5'($urandom_range(0, 7));
        rb  = 5'($urandom_range(0, 7));
        imm = ($urandom_range(0, 2) == 0) ? (16'hC000 | 16'($urandom_range(0, 3)))
                                          : 16'($urandom_range(0, 7));
        case ($urandom_range(0, 9))
          0, 1, 2, 3: begin
            fn = ($urandom_range(0, 11) == 0) ? 6'h3F : 6'($urandom_range(1, 10));
            imem[i] = i_alu(rd, ra, rb, fn);
          end
          4, 5: imem[i] = i_mem(T_LD, rd, imm);
          6:    imem[i] = i_mem(T_SD, rd, imm);
          7:    imem[i] = i_mem(T_BEZ,  rd, 16'($urandom_range(i + 1, n) * 4));
          8:    imem[i] = i_mem(T_BNEZ, rd, 16'($urandom_range(i + 1, n) * 4));
          default: imem[i] = {6'b110000, 26'($urandom)};
        endcase
      end
      model_run();
      do_reset();
      repeat (120) @(negedge clk);
      for (int r = 0; r < 32; r++)
        check($sformatf("rand%0d_r%0d", p, r), dut.regFile.regFile[r], m_reg[r]);
      for (int i = 0; i < 8; i++)
        check($sformatf("rand%0d_m%0d", p, i), dmem[i], m_mem[i]);
      for (int i = 0; i < 4; i++)
        check($sformatf("rand%0d_nic%0d", p, i), nic[i], m_nic[i]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ring_cpu_core.md
Name: ring_cpu_core

Overview:
- 64-bit, 4-stage in-order CPU (IF, ID, EX, WB) for a ring-NoC node.
- Fetches 32-bit instructions from a combinational instruction memory.
- Accesses a synchronous 64-bit data memory and a 4-register NIC window through load/store.
- Bit 0 is the MSB on every bus.

Parameters:
- RESET_PC, 32'h0, PC value loaded on reset.
- DATA_W, 64, register, ALU and memory data width (fixed at 64).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- instrIn  input  32  instruction word at instrAddr (combinational imem).
- instrAddr  output  32  byte PC; the imem indexes word instrAddr[22:29].
- dmemDataIn  input  64  dmem read data, valid the cycle after a read request.
- dmemAddr  output  32  dmem address, {16'b0, imm16}.
- dmemEn  output  1  dmem access enable.
- dmemWrEn  output  1  1 = write, 0 = read (qualified by dmemEn).
- dmemDataOut  output  64  store data.
- nicDataIn  input  64  NIC read data, valid the cycle after a read request.
- nicAddr  output  2  NIC register select.
- nicEn  output  1  NIC access enable.
- nicWrEn  output  1  NIC write.
- nicDataOut  output  64  NIC store data.

Behaviour:
- Encoding:
  - [0:5] opcode, [6:10] rD, [11:15] rA, [16:20] rB, [16:31] imm16, [26:31] func.
- Opcodes:
  - 000000 NOP. The all-zero word is NOP and marks end of program.
  - 101010 ALU: rD ← f(rA, rB).
  - 100000 LD: rD ← M[imm16].
  - 100001 SD: M[imm16] ← rD.
  - 100010 BEZ: if rD == 0, PC ← {16'b0, imm16}.
  - 100011 BNEZ: if rD != 0, PC ← {16'b0, imm16}.
  - Any other opcode executes as NOP.
- ALU func codes:
  - 000001 ADD, 000010 SUB (mod 2^64).
  - 000011 AND, 000100 OR, 000101 XOR.
  - 000110 NOT rA, 000111 MOV rA.
  - 001000 SLL, 001001 SRL, 001010 SRA: shift rA by rB[58:63].
  - Unknown func: no register write.
- Register file: 32 x 64-bit.
  - R0 reads 0; writes to R0 are discarded.
  - Write-through: a WB write is visible to the ID read in the same cycle.
- Address decode for LD/SD:
  - imm16[0:1] == 2'b11 selects the NIC, with nicAddr = imm16[14:15].
  - Otherwise dmem is selected.
  - Exactly one of dmemEn/nicEn is asserted, only during EX of LD/SD.
- Memory timing:
  - Address, enable, write-enable and store data are driven combinationally in EX; the memory samples them at the end of EX.
  - Read data is captured into rD at the end of WB.
  - Load-to-use latency: 2 cycles.
- Fetch: PC += 4 each cycle unless stalled or redirected.
- Branches:
  - Resolved in ID.
  - Taken: the instruction fetched behind the branch is squashed to NOP (1 bubble), and PC ← target on the next edge.
- Hazard interlock:
  - Condition: the EX-stage instruction writes a register that the ID instruction reads (rA, rB for ALU; rD for SD/BEZ/BNEZ).
  - Action: IF and ID hold and a NOP is injected into EX.
  - At most 1 stall cycle per dependence.
  - A WB-stage dependence needs no stall (write-through).
- Reset (asynchronous):
  - PC = RESET_PC, all pipeline registers = NOP, all registers = 0.
  - dmemEn, dmemWrEn, nicEn, nicWrEn = 0; dmemAddr, dmemDataOut, nicDataOut, nicAddr = 0.
  - Reset asserted mid-operation aborts any in-flight store; no partial write.
- Pipeline drain: after the first all-zero word is fetched, all prior instructions are architecturally complete within 4 cycles.

Optional Feature:
- Macro CPU_FWD_EN.
- Defined: an ALU result in EX is forwarded to ID operands, so ALU-to-ALU, ALU-to-SD and ALU-to-branch dependences do not stall. LD results in EX still cause the 1-cycle stall.
- Undefined: every EX dependence stalls as described in Behaviour.

Decomposition:
- Package ring_cpu_pkg: opcode and func localparams, stage-record typedefs (valid, opcode, rD, operands, imm16, write flag), NOP constant.
- One sub-module ring_cpu_regfile, instantiated as regFile with storage array regFile[0:31]. Benches dump it hierarchically.

Test Plan:
- ALU chain: LD R1 ← M[0]=5, LD R2 ← M[1]=3, ADD R3, SUB R4, SLL R5 = R1 << R2, then a zero word. After drain: R3=8, R4=2, R5=40.
- Store: SD R3 → M[4]. Required: dmemEn=1 and dmemWrEn=1 for exactly one cycle, dmemAddr=4, dmemDataOut=8. M[4] dump = 8.
- Branch: R6=0 then BEZ R6, target 0x20. The next sequential instruction is squashed (its rD unchanged) and instrAddr=0x20 two cycles after the branch is fetched.
- Hazard: ADD R7 = R1+R1 immediately followed by ADD R8 = R7+R7. Without CPU_FWD_EN, one stall cycle (instrAddr holds); R8 = 20. With CPU_FWD_EN, no stall; R8 = 20.
- NIC: SD R1 → imm 0xC002 gives nicEn=1, nicWrEn=1, nicAddr=2, nicDataOut=5. LD R9 ← 0xC003 with nicDataIn=0xAA gives R9=0xAA. dmemEn stays 0 throughout.
- Reset mid-run: assert reset during an SD's EX cycle. All enables drop to 0 immediately, PC=0 and registers=0.
